// File: rtl/act_sched.sv
// rtl/act_sched.sv - round-robin scheduler sharing one pipelined activation unit
//
// Grants one requester at a time for a whole burst, issues each accepted
// operand to a pipelined activation unit one cycle after the handshake, and
// routes the unit's result back to the originating requester when a tag
// pipeline matching the unit latency reaches its final stage.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   req_valid/data/last     per-requester operand stream (data packed per requester)
//   req_ready               per-requester accept, at most one bit set
//   act_valid, act_data     registered operand issue to the activation unit
//   act_result              activation unit output, ACT_LATENCY cycles after issue
//   rsp_valid               one-hot result strobe to the issuing requester
//   rsp_data, rsp_last      result value and end-of-burst marker
//   busy                    burst granted or any result still in flight
module act_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BITS   = 16,
    parameter int ACT_LATENCY = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         act_valid,
    output logic [DATA_BITS-1:0]         act_data,
    input  logic [DATA_BITS-1:0]         act_result,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_BITS-1:0]         rsp_data,
    output logic                         rsp_last,
    output logic                         busy
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last_grant;

    // Owner/last of the operand currently on act_data; these feed the tag
    // pipeline so the tag enters in step with act_valid.
    logic [OW-1:0] issue_owner;
    logic          issue_last;

    logic          tag_valid [ACT_LATENCY];
    logic [OW-1:0] tag_owner [ACT_LATENCY];
    logic          tag_last  [ACT_LATENCY];

    logic          handshake;
    logic          pick_found;
    logic [OW-1:0] pick_idx;
    logic          tags_busy;

    assign handshake = (state == GRANT) && req_valid[owner];

    // Round-robin pick: first valid requester after last_grant, with wrap.
    always_comb begin
        int            cand;
        logic [OW-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(last_grant) + 1 + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = OW'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            last_grant  <= OW'(NUM_REQ - 1);
            act_valid   <= 1'b0;
            act_data    <= '0;
            issue_owner <= '0;
            issue_last  <= 1'b0;
        end else begin
            act_valid <= handshake;
            if (handshake) begin
                act_data    <= req_data[int'(owner)*DATA_BITS +: DATA_BITS];
                issue_owner <= owner;
                issue_last  <= req_last[owner];
            end
            if (state == IDLE) begin
                if (pick_found) begin
                    state <= GRANT;
                    owner <= pick_idx;
                end
            end else begin
                // Bursts end only on an accepted last element; a dropped
                // valid just bubbles while the grant is held.
                if (handshake && req_last[owner]) begin
                    state      <= IDLE;
                    last_grant <= owner;
                end
            end
        end
    end

    // Tag pipeline never stalls; it mirrors the activation unit's latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ACT_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
            end
        end else begin
            tag_valid[0] <= act_valid;
            for (int i = 1; i < ACT_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
            end
        end
        tag_owner[0] <= issue_owner;
        tag_last[0]  <= issue_last;
        for (int i = 1; i < ACT_LATENCY; i++) begin
            tag_owner[i] <= tag_owner[i-1];
            tag_last[i]  <= tag_last[i-1];
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == GRANT) begin
            req_ready[owner] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_last  = 1'b0;
        if (tag_valid[ACT_LATENCY-1]) begin
            rsp_valid[tag_owner[ACT_LATENCY-1]] = 1'b1;
            rsp_last = tag_last[ACT_LATENCY-1];
        end
    end

    assign rsp_data = act_result;

    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i < ACT_LATENCY; i++) begin
            tags_busy = tags_busy | tag_valid[i];
        end
    end

    assign busy = (state == GRANT) | act_valid | tags_busy;

endmodule

// File: tb/tb_act_sched.sv
// tb/tb_act_sched.sv - directed and scoreboard bench for act_sched
module tb_act_sched;

    localparam int NR = 4;
    localparam int DB = 16;
    localparam int L  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DB-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              act_valid;
    logic [DB-1:0]     act_data;
    logic [DB-1:0]     act_result;
    logic [NR-1:0]     rsp_valid;
    logic [DB-1:0]     rsp_data;
    logic              rsp_last;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    act_sched #(.NUM_REQ(NR), .DATA_BITS(DB), .ACT_LATENCY(L)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .act_valid  (act_valid),
        .act_data   (act_data),
        .act_result (act_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Piecewise tanh approximation in Q8.8: linear to 0.5, half slope to
    // 1.5, saturated at 1.0 beyond.
    function automatic logic [15:0] htanh(input logic [15:0] x);
        int a;
        int y;
        a = int'($signed(x));
        if (a < 0) a = -a;
        if (a <= 128)      y = a;
        else if (a < 384)  y = 128 + (a - 128) / 2;
        else               y = 256;
        if ($signed(x) < 0) y = -y;
        return 16'(y);
    endfunction

    // Activation unit model: fixed latency L from act_data issue.
    logic [15:0] au_pipe [L];
    initial begin
        for (int i = 0; i < L; i++) au_pipe[i] = 16'h0;
    end
    always @(posedge clock) begin
        au_pipe[0] <= act_data;
        for (int i = 1; i < L; i++) au_pipe[i] <= au_pipe[i-1];
    end
    assign act_result = htanh(au_pipe[L-1]);

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tick();
        tick();
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        total++; if (rsp_last !== 1'b0) begin bad++; $display("FAIL reset_rsp_last got=%b exp=0", rsp_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (act_valid !== 1'b0) begin bad++; $display("FAIL reset_act_valid got=%b exp=0", act_valid); end
        total++; if (act_data !== 16'h0000) begin bad++; $display("FAIL reset_act_data got=%h exp=0000", act_data); end
        total++; if (rsp_data !== act_result) begin bad++; $display("FAIL reset_rsp_data got=%h exp=%h", rsp_data, act_result); end
        reset = 1'b0;
        tick();
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_release_ready got=%b exp=0000", req_ready); end
    endtask

    task automatic test_single_burst();
        logic [3:0]  t_rv [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        logic [15:0] t_d  [10] = '{16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic        t_l  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0]  e_rdy[10] = '{4'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        logic        e_av [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] e_ad [10] = '{16'h0, 16'h0, 16'h0100, 16'h0200, 16'h0300, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [3:0]  e_rv [10] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0};
        logic        e_rl [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] e_op [10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0200, 16'h0300, 16'h0};
        logic        e_bz [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 10; k++) begin
            req_valid = t_rv[k];
            req_data  = '0;
            req_data[2*DB +: DB] = t_d[k];
            req_last  = t_l[k] ? 4'b0100 : 4'b0000;
            total++; if (req_ready !== e_rdy[k]) begin bad++; $display("FAIL single_ready k=%0d got=%b exp=%b", k, req_ready, e_rdy[k]); end
            total++; if (act_valid !== e_av[k]) begin bad++; $display("FAIL single_act_valid k=%0d got=%b exp=%b", k, act_valid, e_av[k]); end
            if (e_av[k]) begin
                total++; if (act_data !== e_ad[k]) begin bad++; $display("FAIL single_act_data k=%0d got=%h exp=%h", k, act_data, e_ad[k]); end
            end
            total++; if (rsp_valid !== e_rv[k]) begin bad++; $display("FAIL single_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, e_rv[k]); end
            total++; if (rsp_last !== e_rl[k]) begin bad++; $display("FAIL single_rsp_last k=%0d got=%b exp=%b", k, rsp_last, e_rl[k]); end
            if (e_rv[k] != 4'b0) begin
                total++; if (rsp_data !== htanh(e_op[k])) begin bad++; $display("FAIL single_rsp_data k=%0d got=%h exp=%h", k, rsp_data, htanh(e_op[k])); end
            end
            total++; if (busy !== e_bz[k]) begin bad++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, e_bz[k]); end
            tick();
        end
    endtask

    task automatic drain();
        req_valid = '0;
        req_last  = '0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] e_g [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_data = {16'h0300, 16'h0200, 16'h0100, 16'h0080};
        for (int g = 0; g < 6; g++) begin
            req_valid = 4'b1011;
            req_last  = 4'b1111;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_idle g=%0d got=%b exp=0000", g, req_ready); end
            tick();
            total++; if (req_ready !== e_g[g]) begin bad++; $display("FAIL rr_grant g=%0d got=%b exp=%b", g, req_ready, e_g[g]); end
            tick();
        end
        drain();
    endtask

    task automatic test_wrap();
        req_valid = 4'b1001;
        req_last  = 4'b1111;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL wrap_idle got=%b exp=0000", req_ready); end
        tick();
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_first got=%b exp=0001", req_ready); end
        tick();
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL wrap_gap got=%b exp=0000", req_ready); end
        tick();
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_second got=%b exp=1000", req_ready); end
        tick();
        drain();
    endtask

    task automatic test_bubble();
        logic [3:0]  t_rv [12] = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0110, 4'b0110, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        logic [15:0] t_d  [12] = '{16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0080, 16'hff80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic        t_l  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0]  e_rdy[12] = '{4'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        logic        e_av [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] e_ad [12] = '{16'h0, 16'h0, 16'h0040, 16'h0, 16'h0, 16'h0080, 16'hff80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [3:0]  e_rv [12] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0, 4'b0, 4'b0010, 4'b0010, 4'b0};
        logic        e_rl [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] e_op [12] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0040, 16'h0, 16'h0, 16'h0080, 16'hff80, 16'h0};
        logic        e_bz [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 12; k++) begin
            req_valid = t_rv[k];
            req_data  = '0;
            req_data[1*DB +: DB] = t_d[k];
            req_data[2*DB +: DB] = 16'h7777;
            req_last  = t_l[k] ? 4'b0010 : 4'b0000;
            total++; if (req_ready !== e_rdy[k]) begin bad++; $display("FAIL bubble_ready k=%0d got=%b exp=%b", k, req_ready, e_rdy[k]); end
            total++; if (act_valid !== e_av[k]) begin bad++; $display("FAIL bubble_act_valid k=%0d got=%b exp=%b", k, act_valid, e_av[k]); end
            if (e_av[k]) begin
                total++; if (act_data !== e_ad[k]) begin bad++; $display("FAIL bubble_act_data k=%0d got=%h exp=%h", k, act_data, e_ad[k]); end
            end
            total++; if (rsp_valid !== e_rv[k]) begin bad++; $display("FAIL bubble_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, e_rv[k]); end
            total++; if (rsp_last !== e_rl[k]) begin bad++; $display("FAIL bubble_rsp_last k=%0d got=%b exp=%b", k, rsp_last, e_rl[k]); end
            if (e_rv[k] != 4'b0) begin
                total++; if (rsp_data !== htanh(e_op[k])) begin bad++; $display("FAIL bubble_rsp_data k=%0d got=%h exp=%h", k, rsp_data, htanh(e_op[k])); end
            end
            total++; if (busy !== e_bz[k]) begin bad++; $display("FAIL bubble_busy k=%0d got=%b exp=%b", k, busy, e_bz[k]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data  = '0;
        req_data[0 +: DB] = 16'h0123;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_idle got=%b exp=0000", req_ready); end
        tick();
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_grant got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        total++; if (act_valid !== 1'b1 || act_data !== 16'h0123) begin bad++; $display("FAIL rmid_issue got=%b/%h exp=1/0123", act_valid, act_data); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        reset = 1'b1;
        tick();
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_ready got=%b exp=0000", req_ready); end
        total++; if (act_valid !== 1'b0) begin bad++; $display("FAIL rmid_act_valid got=%b exp=0", act_valid); end
        total++; if (act_data !== 16'h0000) begin bad++; $display("FAIL rmid_act_data got=%h exp=0000", act_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (rsp_valid !== 4'b0000 || rsp_last !== 1'b0) begin bad++; $display("FAIL rmid_rsp got=%b/%b exp=0000/0", rsp_valid, rsp_last); end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rmid_ghost_rsp k=%0d got=%b exp=0000", k, rsp_valid); end
        end
    endtask

    task automatic test_scoreboard();
        int          q_who [$];
        int          q_due [$];
        logic [15:0] q_dat [$];
        logic        q_lst [$];
        int          rem [NR];
        logic [NR-1:0] hs;
        int          who;
        int          due;
        logic [15:0] dat;
        logic        lst;
        for (int i = 0; i < NR; i++) rem[i] = 0;
        for (int c = 0; c < 400; c++) begin
            if (rsp_valid !== 4'b0000) begin
                total++;
                if (q_who.size() == 0) begin
                    bad++; $display("FAIL sb_unexpected cyc=%0d got=%b exp=0000", cyc, rsp_valid);
                end else begin
                    who = q_who.pop_front();
                    due = q_due.pop_front();
                    dat = q_dat.pop_front();
                    lst = q_lst.pop_front();
                    total++; if (rsp_valid !== 4'(1 << who)) begin bad++; $display("FAIL sb_route cyc=%0d got=%b exp=%b", cyc, rsp_valid, 4'(1 << who)); end
                    total++; if (cyc !== due) begin bad++; $display("FAIL sb_latency got=%0d exp=%0d", cyc, due); end
                    total++; if (rsp_data !== htanh(dat)) begin bad++; $display("FAIL sb_data cyc=%0d got=%h exp=%h", cyc, rsp_data, htanh(dat)); end
                    total++; if (rsp_last !== lst) begin bad++; $display("FAIL sb_last cyc=%0d got=%b exp=%b", cyc, rsp_last, lst); end
                end
            end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
                total++; bad++;
                $display("FAIL sb_missing cyc=%0d got=0000 exp_due=%0d", cyc, q_due[0]);
                void'(q_who.pop_front()); void'(q_due.pop_front());
                void'(q_dat.pop_front()); void'(q_lst.pop_front());
            end
            total++; if ($countones(req_ready) > 1) begin bad++; $display("FAIL sb_ready_onehot cyc=%0d got=%b", cyc, req_ready); end
            for (int i = 0; i < NR; i++) begin
                if (rem[i] == 0 && c < 300 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
                req_valid[i] = (rem[i] != 0) && ($urandom_range(0, 9) < 7);
                req_last[i]  = (rem[i] == 1);
                req_data[i*DB +: DB] = 16'($urandom);
            end
            hs = req_valid & req_ready;
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    q_who.push_back(i);
                    q_due.push_back(cyc + 1 + L);
                    q_dat.push_back(req_data[i*DB +: DB]);
                    q_lst.push_back(req_last[i]);
                    rem[i]--;
                end
            end
            tick();
        end
        req_valid = '0;
        total++; if (q_who.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", q_who.size()); end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_wrap();
        test_bubble();
        test_reset_mid();
        test_scoreboard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
